// File: rtl/mem_arb_2023211063.sv
// mem_arb_2023211063: two-master (EX load/store, instruction fetch) arbiter
// sharing one request/acknowledge slave port, with pipeline hold flag and
// slave-stall timeout.
//
// Build option: define ARB_RR_EN for round-robin arbitration between
// simultaneous requests; otherwise EX has fixed priority over fetch.
//
// state  | meaning
// IDLE   | no transaction; arbitrate and latch the winner's request
// GNT_EX | EX transaction on the slave port, waiting for ack or timeout
// GNT_IF | fetch transaction on the slave port, waiting for ack or timeout

module mem_arb_2023211063 #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_req_i,
  input  logic        ex_we_i,
  input  logic [31:0] ex_addr_i,
  input  logic [31:0] ex_wdata_i,
  output logic [31:0] ex_rdata_o,
  output logic        ex_ack_o,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_rdata_o,
  output logic        if_ack_o,
  output logic        slv_req_o,
  output logic        slv_we_o,
  output logic [31:0] slv_addr_o,
  output logic [31:0] slv_wdata_o,
  input  logic [31:0] slv_rdata_i,
  input  logic        slv_ack_i,
  output logic        hold_flag_o,
  output logic        err_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_EX = 2'd1,
    GNT_IF = 2'd2
  } state_t;

  // Last granted cycle before forced termination (counter starts at 0).
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYC - 1);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] cnt;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic        lat_we;
  logic        pick_ex;
  logic        pick_if;
  logic        timeout;
  logic        finish;

`ifdef ARB_RR_EN
  // 1 when EX won the most recent grant; reset value favours EX next.
  logic last_ex;

  // Round-robin pick: on contention, grant whichever master did not win last.
  always_comb begin
    pick_ex = 1'b0;
    pick_if = 1'b0;
    if (ex_req_i && if_req_i) begin
      pick_ex = ~last_ex;
      pick_if = last_ex;
    end else begin
      pick_ex = ex_req_i;
      pick_if = if_req_i;
    end
  end

  // Remember the winner of each grant taken from IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_ex <= 1'b0;
    end else if ((state == IDLE) && (pick_ex || pick_if)) begin
      last_ex <= pick_ex;
    end
  end
`else
  // Fixed priority pick: EX always beats fetch.
  always_comb begin
    pick_ex = ex_req_i;
    pick_if = if_req_i & ~ex_req_i;
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and master/slave handshake outputs.
  always_comb begin
    state_nxt  = state;
    slv_req_o  = 1'b0;
    ex_ack_o   = 1'b0;
    if_ack_o   = 1'b0;
    ex_rdata_o = 32'd0;
    if_rdata_o = 32'd0;
    err_o      = 1'b0;
    timeout    = 1'b0;
    finish     = 1'b0;
    unique case (state)
      IDLE: begin
        if (pick_ex) begin
          state_nxt = GNT_EX;
        end else if (pick_if) begin
          state_nxt = GNT_IF;
        end
      end
      GNT_EX, GNT_IF: begin
        slv_req_o = 1'b1;
        // A real ack on the last allowed cycle beats the timeout.
        timeout   = ~slv_ack_i && (cnt == CNT_LAST);
        finish    = slv_ack_i | timeout;
        err_o     = timeout;
        if (state == GNT_EX) begin
          ex_ack_o   = finish;
          ex_rdata_o = slv_ack_i ? slv_rdata_i : 32'd0;
        end else begin
          if_ack_o   = finish;
          if_rdata_o = slv_ack_i ? slv_rdata_i : 32'd0;
        end
        if (finish) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Timeout counter: held at zero in IDLE so each grant starts from 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= 16'd0;
    end else if (state == IDLE) begin
      cnt <= 16'd0;
    end else if (!finish) begin
      cnt <= cnt + 16'd1;
    end
  end

  // Capture the winner's request so the slave sees stable values for the whole grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_addr  <= 32'd0;
      lat_we    <= 1'b0;
      lat_wdata <= 32'd0;
    end else if (state == IDLE) begin
      if (pick_ex) begin
        lat_addr  <= ex_addr_i;
        lat_we    <= ex_we_i;
        lat_wdata <= ex_wdata_i;
      end else if (pick_if) begin
        lat_addr  <= if_addr_i;
        lat_we    <= 1'b0;
        lat_wdata <= 32'd0;
      end
    end
  end

  // Slave command fields are quiet outside a grant.
  assign slv_addr_o  = slv_req_o ? lat_addr  : 32'd0;
  assign slv_we_o    = slv_req_o & lat_we;
  assign slv_wdata_o = slv_req_o ? lat_wdata : 32'd0;

  assign hold_flag_o = (ex_req_i & ~ex_ack_o) | (if_req_i & ~if_ack_o);

endmodule

// File: tb/tb_mem_arb_2023211063.sv
// Testbench for mem_arb_2023211063: directed scenarios with literal
// expectations plus randomized traffic against a transaction-level model.

module tb_mem_arb_2023211063;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ex_req_i = 1'b0;
  logic        ex_we_i = 1'b0;
  logic [31:0] ex_addr_i = '0;
  logic [31:0] ex_wdata_i = '0;
  logic [31:0] ex_rdata_o;
  logic        ex_ack_o;
  logic        if_req_i = 1'b0;
  logic [31:0] if_addr_i = '0;
  logic [31:0] if_rdata_o;
  logic        if_ack_o;
  logic        slv_req_o;
  logic        slv_we_o;
  logic [31:0] slv_addr_o;
  logic [31:0] slv_wdata_o;
  logic [31:0] slv_rdata_i = '0;
  logic        slv_ack_i = 1'b0;
  logic        hold_flag_o;
  logic        err_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_arb_2023211063 #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .ex_req_i(ex_req_i), .ex_we_i(ex_we_i), .ex_addr_i(ex_addr_i),
    .ex_wdata_i(ex_wdata_i), .ex_rdata_o(ex_rdata_o), .ex_ack_o(ex_ack_o),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o),
    .if_ack_o(if_ack_o),
    .slv_req_o(slv_req_o), .slv_we_o(slv_we_o), .slv_addr_o(slv_addr_o),
    .slv_wdata_o(slv_wdata_o), .slv_rdata_i(slv_rdata_i), .slv_ack_i(slv_ack_i),
    .hold_flag_o(hold_flag_o), .err_o(err_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  // Transaction-level model: who owns the bus (0 none, 1 EX, 2 IF), how many
  // granted cycles have elapsed, what was captured at grant, and who won last.
  int          m_cur  = 0;
  int          m_age  = 0;
  int          m_last = 2;
  logic [31:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  logic        m_we = 1'b0;

  always @(negedge clk) begin : compare
    logic        e_req, e_we, e_exa, e_ifa, e_err, e_hold, fin, to;
    logic [31:0] e_addr, e_wd, e_exr, e_ifr;
    int          win;
    e_req = 0; e_we = 0; e_exa = 0; e_ifa = 0; e_err = 0; e_hold = 0;
    e_addr = 0; e_wd = 0; e_exr = 0; e_ifr = 0;
    fin = 0; to = 0; win = 0;
    if (!rst) begin
      e_hold = ex_req_i | if_req_i;
      m_cur = 0; m_age = 0; m_last = 2;
    end else if (m_cur == 0) begin
      e_hold = ex_req_i | if_req_i;
      if (ex_req_i && if_req_i) begin
`ifdef ARB_RR_EN
        win = (m_last == 1) ? 2 : 1;
`else
        win = 1;
`endif
      end else if (ex_req_i) begin
        win = 1;
      end else if (if_req_i) begin
        win = 2;
      end
      if (win == 1) begin
        m_addr = ex_addr_i; m_we = ex_we_i; m_wdata = ex_wdata_i;
      end else if (win == 2) begin
        m_addr = if_addr_i; m_we = 0; m_wdata = 0;
      end
      if (win != 0) begin
        m_cur = win; m_age = 0; m_last = win;
      end
    end else begin
      e_req = 1; e_addr = m_addr; e_we = m_we; e_wd = m_wdata;
      to  = !slv_ack_i && (m_age == TO - 1);
      fin = slv_ack_i || to;
      e_err = to;
      if (m_cur == 1) begin
        e_exa = fin; e_exr = slv_ack_i ? slv_rdata_i : 32'd0;
      end else begin
        e_ifa = fin; e_ifr = slv_ack_i ? slv_rdata_i : 32'd0;
      end
      e_hold = (ex_req_i && !e_exa) || (if_req_i && !e_ifa);
      if (fin) m_cur = 0;
      else m_age++;
    end
    chk("m_slv_req", slv_req_o, e_req);
    chk("m_slv_we", slv_we_o, e_we);
    chk("m_slv_addr", slv_addr_o, e_addr);
    chk("m_slv_wdata", slv_wdata_o, e_wd);
    chk("m_ex_ack", ex_ack_o, e_exa);
    chk("m_ex_rdata", ex_rdata_o, e_exr);
    chk("m_if_ack", if_ack_o, e_ifa);
    chk("m_if_rdata", if_rdata_o, e_ifr);
    chk("m_err", err_o, e_err);
    chk("m_hold", hold_flag_o, e_hold);
  end

  initial begin : watchdog
    #500000;
    errors++;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 500000", $time);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  task automatic reset_pulse();
    step();
    rst = 0;
    step();
    rst = 1;
  endtask

  initial begin : main
    int   seq [5];
    int   exp_seq [5];
    int   nacks;
    logic ex_acked, if_acked;

    // Reset state, hold flag follows requests even in reset
    ex_req_i = 1;
    step(); step();
    at_neg();
    chk("rst_hold_req", hold_flag_o, 1);
    chk("rst_slv_req", slv_req_o, 0);
    chk("rst_ex_ack", ex_ack_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_slv_addr", slv_addr_o, 0);
    step();
    ex_req_i = 0;
    at_neg();
    chk("rst_hold_idle", hold_flag_o, 0);
    step();
    rst = 1;

    // Single fetch, slave acks on the first granted cycle
    step();
    if_req_i = 1; if_addr_i = 32'h0000_0100;
    at_neg();
    chk("t1_hold_wait", hold_flag_o, 1);
    chk("t1_req_idle", slv_req_o, 0);
    step();
    slv_ack_i = 1; slv_rdata_i = 32'h0000_0013;
    at_neg();
    chk("t1_slv_req", slv_req_o, 1);
    chk("t1_slv_addr", slv_addr_o, 32'h100);
    chk("t1_if_ack", if_ack_o, 1);
    chk("t1_if_rdata", if_rdata_o, 32'h13);
    chk("t1_ex_ack", ex_ack_o, 0);
    step();
    if_req_i = 0; slv_ack_i = 0; slv_rdata_i = 0;
    at_neg();
    chk("t1_hold_after", hold_flag_o, 0);
    chk("t1_req_after", slv_req_o, 0);

    // EX write, slave acks on the third granted cycle
    step();
    ex_req_i = 1; ex_we_i = 1; ex_addr_i = 32'h1000_0004; ex_wdata_i = 32'hDEAD_BEEF;
    at_neg();
    chk("t2_hold_wait", hold_flag_o, 1);
    for (int g = 1; g <= 3; g++) begin
      step();
      if (g == 3) begin
        slv_ack_i = 1; slv_rdata_i = 32'h0000_0055;
      end
      at_neg();
      chk("t2_slv_we", slv_we_o, 1);
      chk("t2_slv_wdata", slv_wdata_o, 32'hDEAD_BEEF);
      chk("t2_slv_addr", slv_addr_o, 32'h1000_0004);
      chk("t2_ex_ack", ex_ack_o, (g == 3) ? 32'd1 : 32'd0);
      chk("t2_hold", hold_flag_o, (g == 3) ? 32'd0 : 32'd1);
    end
    step();
    ex_req_i = 0; ex_we_i = 0; slv_ack_i = 0; slv_rdata_i = 0;
    at_neg();
    chk("t2_ex_ack_after", ex_ack_o, 0);

    // Contention, slave always acks immediately
    reset_pulse();
    step();
    ex_req_i = 1; ex_addr_i = 32'h2000_0000; if_req_i = 1; if_addr_i = 32'h0000_0800;
    nacks = 0;
    for (int c = 0; c < 60 && nacks < 5; c++) begin
      at_neg();
      if (ex_ack_o) begin seq[nacks] = 1; nacks++; end
      else if (if_ack_o) begin seq[nacks] = 2; nacks++; end
      step();
      if (nacks >= 4) ex_req_i = 0;
      if (nacks >= 5) if_req_i = 0;
      slv_ack_i = slv_req_o;
      slv_rdata_i = $urandom;
    end
    slv_ack_i = 0;
    ex_req_i = 0; if_req_i = 0;
`ifdef ARB_RR_EN
    exp_seq = '{1, 2, 1, 2, 2};
`else
    exp_seq = '{1, 1, 1, 1, 2};
`endif
    chk("t3_ack_count", nacks, 5);
    for (int i = 0; i < 5; i++) begin
      if (i < nacks) chk("t3_winner", seq[i], exp_seq[i]);
    end

    // Timeout, slave never acks
    step();
    if_req_i = 1; if_addr_i = 32'h0000_0200; slv_rdata_i = 32'hFFFF_FFFF;
    for (int g = 1; g <= 4; g++) begin
      step();
      at_neg();
      chk("t4_slv_req", slv_req_o, 1);
      chk("t4_err", err_o, (g == 4) ? 32'd1 : 32'd0);
      chk("t4_if_ack", if_ack_o, (g == 4) ? 32'd1 : 32'd0);
      chk("t4_if_rdata", if_rdata_o, 0);
    end
    step();
    if_req_i = 0;
    at_neg();
    chk("t4_idle_after", slv_req_o, 0);
    chk("t4_err_after", err_o, 0);

    // Reset in the second granted cycle, then a normal grant
    step();
    ex_req_i = 1; ex_we_i = 0; ex_addr_i = 32'h0000_0300;
    step();
    step();
    rst = 0;
    #1;
    chk("t5_req_in_rst", slv_req_o, 0);
    chk("t5_ack_in_rst", ex_ack_o, 0);
    chk("t5_err_in_rst", err_o, 0);
    step();
    rst = 1;
    at_neg();
    chk("t5_idle_release", slv_req_o, 0);
    step();
    slv_ack_i = 1; slv_rdata_i = 32'h0000_1234;
    at_neg();
    chk("t5_regrant_req", slv_req_o, 1);
    chk("t5_regrant_addr", slv_addr_o, 32'h300);
    chk("t5_regrant_ack", ex_ack_o, 1);
    chk("t5_regrant_rdata", ex_rdata_o, 32'h1234);
    step();
    ex_req_i = 0; slv_ack_i = 0; slv_rdata_i = 0;

    // Ack arrives exactly on the timeout cycle
    step();
    if_req_i = 1; if_addr_i = 32'h0000_0400;
    for (int g = 1; g <= 4; g++) begin
      step();
      if (g == 4) begin
        slv_ack_i = 1; slv_rdata_i = 32'hCAFE_0001;
      end
      at_neg();
      if (g == 4) begin
        chk("t6_if_ack", if_ack_o, 1);
        chk("t6_if_rdata", if_rdata_o, 32'hCAFE_0001);
        chk("t6_err", err_o, 0);
      end
    end
    step();
    if_req_i = 0; slv_ack_i = 0; slv_rdata_i = 0;

    // Randomized traffic, checked by the model on every cycle
    for (int c = 0; c < 3000; c++) begin
      at_neg();
      ex_acked = ex_ack_o;
      if_acked = if_ack_o;
      step();
      if (!rst) rst = 1;
      else if ($urandom_range(0, 499) == 0) rst = 0;
      if (ex_acked || !ex_req_i) begin
        if ($urandom_range(0, 9) < 4) begin
          ex_req_i = 1; ex_we_i = 1'($urandom);
          ex_addr_i = $urandom; ex_wdata_i = $urandom;
        end else begin
          ex_req_i = 0;
        end
      end else if ($urandom_range(0, 99) == 0) begin
        ex_req_i = 0;
      end
      if (if_acked || !if_req_i) begin
        if ($urandom_range(0, 9) < 4) begin
          if_req_i = 1; if_addr_i = $urandom;
        end else begin
          if_req_i = 0;
        end
      end else if ($urandom_range(0, 99) == 0) begin
        if_req_i = 0;
      end
      slv_ack_i = slv_req_o && ($urandom_range(0, 2) == 0);
      slv_rdata_i = $urandom;
    end
    at_neg();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
